// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan monitor: segment encodings, FSM states, digit count.
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    function automatic logic [2:0] onehot_idx(input logic [NUM_DIGITS-1:0] oh);
        onehot_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (oh[i]) onehot_idx = 3'(i);
        end
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational decode of an active-low 7-segment pattern into a hex nibble.
// Blank (all segments off) decodes to 0 with o_blank set; anything else unknown flags o_invalid.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_blank,
    output logic       o_invalid
);

    logic [6:0] w_seg;
    assign w_seg = ~i_seg;

    always_comb begin
        o_nibble  = 4'h0;
        o_blank   = 1'b0;
        o_invalid = 1'b0;
        case (w_seg)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
            SEG_A:     o_nibble = 4'hA;
            SEG_B:     o_nibble = 4'hB;
            SEG_C:     o_nibble = 4'hC;
            SEG_D:     o_nibble = 4'hD;
            SEG_E:     o_nibble = 4'hE;
            SEG_F:     o_nibble = 4'hF;
            SEG_BLANK: o_blank  = 1'b1;
            default:   o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Passive monitor that rebuilds the 32-bit hex value from a multiplexed 7-segment scan.
// Define SEG_DP_CAPTURE_EN to add the dp_mask output (decimal points captured per digit).
//
// state  | meaning
// IDLE   | no legal single-digit enable being tracked
// SETTLE | one digit enabled, counting cycles of unchanged enable+segments
// HOLD   | digit captured, waiting for the enable to move on
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  led_en,
    input  logic [6:0]  led_seg,
    input  logic        led_dp,
    output logic [31:0] value,
    output logic        value_valid,
    output logic [7:0]  blank_mask,
    output logic        seg_err,
    output logic        stale
`ifdef SEG_DP_CAPTURE_EN
   ,output logic [7:0]  dp_mask
`endif
);

    state_e      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [7:0]  r_prev_en;
    logic [6:0]  r_prev_seg;
    logic [31:0] r_shadow, r_value;
    logic [7:0]  r_shadow_blank, r_blank_mask, r_mask;
    logic        r_valid, r_err;
    logic [15:0] r_stale_cnt;

    logic [7:0]  w_act, w_cap_bit;
    logic [2:0]  w_idx;
    logic        w_none, w_multi, w_one, w_same, w_fresh, w_hit;
    logic        w_capture, w_err_set, w_commit;
    logic [3:0]  w_nibble;
    logic        w_blank, w_invalid;

    seg_hex_decode u_dec (
        .i_seg     (led_seg),
        .o_nibble  (w_nibble),
        .o_blank   (w_blank),
        .o_invalid (w_invalid)
    );

    assign w_act   = ~led_en;
    assign w_none  = (w_act == 8'h00);
    assign w_multi = ((w_act & (w_act - 8'd1)) != 8'h00);
    assign w_one   = !w_none && !w_multi;
    assign w_idx   = onehot_idx(w_act);
    assign w_same  = (led_en == r_prev_en) && (led_seg == r_prev_seg);

    // A fresh evaluation restarts dwell tracking from the current enable.
    assign w_fresh = (r_state == IDLE)
                  || (r_state == SETTLE && !w_same)
                  || (r_state == HOLD && led_en != r_prev_en);
    assign w_hit   = w_one && !(r_state == HOLD && !w_fresh)
                  && (w_cnt_nxt == 4'(STABLE_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_state == SETTLE && !w_fresh) ? r_cnt + 4'd1 : 4'd1;
        if (r_state == HOLD && !w_fresh)
            w_state_nxt = HOLD;
        else if (!w_one)
            w_state_nxt = IDLE;
        else if (w_hit)
            w_state_nxt = HOLD;
        else
            w_state_nxt = SETTLE;
    end

    always_comb begin
        w_capture = w_hit && !w_invalid;
        w_err_set = (w_fresh && w_multi) || (w_hit && w_invalid);
    end

    assign w_commit  = (r_mask == 8'hFF);
    assign w_cap_bit = w_capture ? (8'b1 << w_idx) : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_en      <= 8'hFF;
            r_prev_seg     <= 7'h7F;
            r_shadow       <= 32'h0;
            r_shadow_blank <= 8'h00;
            r_mask         <= 8'h00;
            r_value        <= 32'h0;
            r_blank_mask   <= 8'h00;
            r_valid        <= 1'b0;
            r_err          <= 1'b0;
            r_stale_cnt    <= 16'h0;
        end else begin
            r_prev_en  <= led_en;
            r_prev_seg <= led_seg;
            r_valid    <= w_commit;
            if (w_err_set) r_err <= 1'b1;
            if (w_capture) begin
                r_shadow[{w_idx, 2'b00} +: 4] <= w_nibble;
                r_shadow_blank[w_idx]         <= w_blank;
            end
            // On commit the mask restarts from this cycle's capture so it is not lost.
            if (w_commit) begin
                r_value      <= r_shadow;
                r_blank_mask <= r_shadow_blank;
                r_mask       <= w_cap_bit;
            end else begin
                r_mask <= r_mask | w_cap_bit;
            end
            if (w_capture)
                r_stale_cnt <= 16'h0;
            else if (r_stale_cnt != 16'(TIMEOUT_CYC))
                r_stale_cnt <= r_stale_cnt + 16'd1;
        end
    end

    assign value       = r_value;
    assign value_valid = r_valid;
    assign blank_mask  = r_blank_mask;
    assign seg_err     = r_err;
    assign stale       = (r_stale_cnt == 16'(TIMEOUT_CYC));

`ifdef SEG_DP_CAPTURE_EN
    logic [7:0] r_shadow_dp, r_dp_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_dp <= 8'h00;
            r_dp_mask   <= 8'h00;
        end else begin
            if (w_capture) r_shadow_dp[w_idx] <= ~led_dp;
            if (w_commit)  r_dp_mask <= r_shadow_dp;
        end
    end

    assign dp_mask = r_dp_mask;
`else
    logic w_unused_dp;
    assign w_unused_dp = led_dp;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: table of full-frame scans plus hand sequences
// for glitch, illegal enable, stale timeout and mid-frame reset.
`timescale 1ns/1ps
module tb_seg_scan_capture;

    localparam int STABLE = 4;
    localparam int TMO    = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  led_en = 8'hFF;
    logic [6:0]  led_seg = 7'h7F;
    logic        led_dp = 1'b1;
    logic [31:0] value;
    logic        value_valid;
    logic [7:0]  blank_mask;
    logic        seg_err;
    logic        stale;
`ifdef SEG_DP_CAPTURE_EN
    logic [7:0]  dp_mask;
`endif

    seg_scan_capture #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .led_en      (led_en),
        .led_seg     (led_seg),
        .led_dp      (led_dp),
        .value       (value),
        .value_valid (value_valid),
        .blank_mask  (blank_mask),
        .seg_err     (seg_err),
        .stale       (stale)
`ifdef SEG_DP_CAPTURE_EN
       ,.dp_mask     (dp_mask)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          vv_cnt = 0;
    int          vv_cyc = 0;
    int          d7_cyc = 0;
    logic [31:0] vv_val = 32'h0;
    logic [7:0]  vv_blank = 8'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (value_valid === 1'b1) begin
            vv_cnt   <= vv_cnt + 1;
            vv_val   <= value;
            vv_blank <= blank_mask;
            vv_cyc   <= cyc;
        end
    end

    typedef struct {
        logic [31:0] disp;
        logic [7:0]  blank;
        logic [31:0] exp_val;
        logic [7:0]  exp_blank;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [6:0] seg_hi(input logic [3:0] n);
        case (n)
            4'h0: seg_hi = 7'h3F;  4'h1: seg_hi = 7'h06;
            4'h2: seg_hi = 7'h5B;  4'h3: seg_hi = 7'h4F;
            4'h4: seg_hi = 7'h66;  4'h5: seg_hi = 7'h6D;
            4'h6: seg_hi = 7'h7D;  4'h7: seg_hi = 7'h07;
            4'h8: seg_hi = 7'h7F;  4'h9: seg_hi = 7'h6F;
            4'hA: seg_hi = 7'h77;  4'hB: seg_hi = 7'h7C;
            4'hC: seg_hi = 7'h39;  4'hD: seg_hi = 7'h5E;
            4'hE: seg_hi = 7'h79;  default: seg_hi = 7'h71;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the n-th following rising edge.
    task automatic drive_digit(input int i, input logic [6:0] seg_n, input int n);
        led_en  = ~(8'b1 << i);
        led_seg = seg_n;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic idle_cycles(input int n);
        led_en  = 8'hFF;
        led_seg = 7'h7F;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic scan_digits(input logic [31:0] v, input logic [7:0] bm, input int ndig);
        for (int i = 0; i < ndig; i++) begin
            if (i == 7) d7_cyc = cyc;
            drive_digit(i, bm[i] ? 7'h7F : ~seg_hi(v[4*i +: 4]), 16);
        end
    endtask

    int          vv0;
    logic [31:0] tmp;

    initial begin
        vecs[0] = '{32'h0000000A, 8'h00, 32'h0000000A, 8'h00};
        vecs[1] = '{32'h00003840, 8'hF0, 32'h00003840, 8'hF0};
        vecs[2] = '{32'h12345678, 8'h00, 32'h12345678, 8'h00};
        vecs[3] = '{32'hFEDCBA98, 8'h00, 32'hFEDCBA98, 8'h00};
        vecs[4] = '{32'hABCD1234, 8'hF0, 32'h00001234, 8'hF0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", value, 32'h0);
        chk("rst_valid", {31'h0, value_valid}, 32'h0);
        chk("rst_blank", {24'h0, blank_mask}, 32'h0);
        chk("rst_err", {31'h0, seg_err}, 32'h0);
        chk("rst_stale", {31'h0, stale}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 5; k++) begin
            vv0 = vv_cnt;
            scan_digits(vecs[k].disp, vecs[k].blank, 8);
            idle_cycles(4);
            chk($sformatf("vec%0d_commits", k), 32'(vv_cnt - vv0), 32'd1);
            chk($sformatf("vec%0d_value", k), vv_val, vecs[k].exp_val);
            chk($sformatf("vec%0d_blank", k), {24'h0, vv_blank}, {24'h0, vecs[k].exp_blank});
            chk($sformatf("vec%0d_err", k), {31'h0, seg_err}, 32'h0);
            chk($sformatf("vec%0d_latency", k), 32'(vv_cyc - d7_cyc), 32'(STABLE + 1));
        end

        // Glitch on digit 2: short dwell, one-cycle change, then the real pattern.
        vv0 = vv_cnt;
        tmp = 32'h00301321;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                drive_digit(2, ~seg_hi(4'h7), 3);
                drive_digit(2, ~seg_hi(4'h8), 1);
                drive_digit(2, ~seg_hi(4'h3), 10);
            end else begin
                drive_digit(i, ~seg_hi(tmp[4*i +: 4]), 16);
            end
        end
        idle_cycles(4);
        chk("glitch_commits", 32'(vv_cnt - vv0), 32'd1);
        chk("glitch_value", vv_val, 32'h00301321);

        // Stale: digit 7 captured 4 edges after it appears, stale 100 edges after that.
        vv0 = vv_cnt;
        scan_digits(32'h00000078, 8'h00, 8);
        chk("stale_frame_value", vv_val, 32'h00000078);
        chk("stale_frame_commits", 32'(vv_cnt - vv0), 32'd1);
        led_en  = 8'hFF;
        led_seg = 7'h7F;
        repeat (87) @(posedge clk);
        @(negedge clk);
        chk("stale_before_timeout", {31'h0, stale}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("stale_at_timeout", {31'h0, stale}, 32'h1);
        @(posedge clk); #1;
        led_en  = 8'hFE;
        led_seg = ~seg_hi(4'h5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stale_held_pre_capture", {31'h0, stale}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("stale_cleared_by_capture", {31'h0, stale}, 32'h0);
        @(posedge clk); #1;
        idle_cycles(2);

        // Two digit enables at once: error flagged, nothing captured.
        vv0 = vv_cnt;
        led_en  = 8'b1111_1100;
        led_seg = ~seg_hi(4'h1);
        repeat (5) begin @(posedge clk); #1; end
        chk("illegal_err", {31'h0, seg_err}, 32'h1);
        idle_cycles(2);
        chk("illegal_no_commit", 32'(vv_cnt - vv0), 32'd0);
        // Digit 0 (value 5) from the stale test is still in the mask; the frame overwrites it.
        scan_digits(32'h000006EF, 8'h00, 8);
        idle_cycles(4);
        chk("after_illegal_commits", 32'(vv_cnt - vv0), 32'd1);
        chk("after_illegal_value", vv_val, 32'h000006EF);
        chk("err_sticky", {31'h0, seg_err}, 32'h1);

        // Reset mid-frame.
        vv0 = vv_cnt;
        scan_digits(32'h00003778, 8'h00, 5);
        rst_n = 1'b0;
        #1;
        chk("midrst_value", value, 32'h0);
        chk("midrst_err", {31'h0, seg_err}, 32'h0);
        chk("midrst_stale", {31'h0, stale}, 32'h0);
        idle_cycles(3);
        chk("midrst_no_commit", 32'(vv_cnt - vv0), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        scan_digits(32'h00003778, 8'h00, 8);
        idle_cycles(4);
        chk("postrst_commits", 32'(vv_cnt - vv0), 32'd1);
        chk("postrst_value", vv_val, 32'h00003778);
        chk("postrst_blank", {24'h0, vv_blank}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
